// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: op encoding, FSM states and operand magnitude helper.
package div_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    // Widest operand the helper below handles; callers sign-extend into it and truncate back.
    localparam int DIV_MAXW = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_t;

    // x must arrive sign-extended to DIV_MAXW; the low bits of the result are the magnitude.
    function automatic logic [DIV_MAXW-1:0] abs_val(input logic [DIV_MAXW-1:0] x,
                                                    input logic signed_op);
        return (signed_op && x[DIV_MAXW-1]) ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {A,Q} left, trial-subtract the divisor, keep or restore.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0] w_sh;
    logic [WIDTH:0] w_trial;
    logic           w_neg;

    // One extra bit keeps the borrow visible when the divisor MSB is set.
    assign w_sh    = {i_a, i_q[WIDTH-1]};
    assign w_trial = w_sh - {1'b0, i_d};
    assign w_neg   = w_trial[WIDTH];

    assign o_a = w_neg ? w_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign o_q = {i_q[WIDTH-2:0], ~w_neg};

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU with RISC-V special-case results.
// Macro DIV_FAST_SPECIAL_EN: divide-by-zero and overflow skip CALC and complete in one cycle.
module iter_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] oper_a,
    input  logic [WIDTH-1:0] oper_b,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] div_o,
    output logic             divided_by_zero,
    output logic             overflow
);

`ifdef DIV_FAST_SPECIAL_EN
    localparam bit FAST_SPECIAL = 1'b1;
`else
    localparam bit FAST_SPECIAL = 1'b0;
`endif

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t r_state, w_next;

    logic [WIDTH-1:0] r_a, r_q, r_dsr, r_raw_a, r_div_o;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic             r_q_neg, r_r_neg, r_dz, r_ovf, r_dz_o, r_ovf_o;

    logic [WIDTH-1:0]    w_a_nxt, w_q_nxt, w_quo, w_rem, w_result;
    logic [DIV_MAXW-1:0] w_a_ext, w_b_ext;
    logic                w_signed, w_a_neg, w_b_neg, w_dz_in, w_ovf_in;
    logic                w_accept, w_last, w_fire, w_is_rem;

    assign w_signed = (op == OP_DIV) || (op == OP_REM);
    assign w_a_neg  = w_signed & oper_a[WIDTH-1];
    assign w_b_neg  = w_signed & oper_b[WIDTH-1];
    assign w_a_ext  = DIV_MAXW'($signed(oper_a));
    assign w_b_ext  = DIV_MAXW'($signed(oper_b));
    assign w_dz_in  = (oper_b == '0);
    assign w_ovf_in = w_signed && (oper_a == MIN_VAL) && (oper_b == '1);

    // kill beats start in IDLE; in FIX it suppresses the done pulse and the result update.
    assign w_accept = (r_state == S_IDLE) && start && !kill;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_fire   = (r_state == S_FIX) && !kill && !rst;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_a (r_a),
        .i_q (r_q),
        .i_d (r_dsr),
        .o_a (w_a_nxt),
        .o_q (w_q_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept)
                         w_next = (FAST_SPECIAL && (w_dz_in || w_ovf_in)) ? S_FIX : S_CALC;
            S_CALC:  if (kill)        w_next = S_IDLE;
                     else if (w_last) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy            = (r_state != S_IDLE);
        done            = w_fire;
        div_o           = w_fire ? w_result : r_div_o;
        divided_by_zero = w_fire ? r_dz     : r_dz_o;
        overflow        = w_fire ? r_ovf    : r_ovf_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_q     <= '0;
            r_dsr   <= '0;
            r_raw_a <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_dz    <= 1'b0;
            r_ovf   <= 1'b0;
            r_div_o <= '0;
            r_dz_o  <= 1'b0;
            r_ovf_o <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= '0;
                r_q     <= WIDTH'(abs_val(w_a_ext, w_signed));
                r_dsr   <= WIDTH'(abs_val(w_b_ext, w_signed));
                r_raw_a <= oper_a;
                r_op    <= op;
                r_cnt   <= '0;
                r_q_neg <= w_a_neg ^ w_b_neg;
                r_r_neg <= w_a_neg;
                r_dz    <= w_dz_in;
                r_ovf   <= w_ovf_in;
            end else if (r_state == S_CALC) begin
                r_a   <= w_a_nxt;
                r_q   <= w_q_nxt;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_fire) begin
                r_div_o <= w_result;
                r_dz_o  <= r_dz;
                r_ovf_o <= r_ovf;
            end
        end
    end

    // Special cases are forced here so the fast path never depends on A/Q contents.
    always_comb begin
        w_is_rem = (r_op == OP_REM) || (r_op == OP_REMU);
        w_quo    = r_q_neg ? (~r_q + 1'b1) : r_q;
        w_rem    = r_r_neg ? (~r_a + 1'b1) : r_a;
        if (r_dz)
            w_result = w_is_rem ? r_raw_a : '1;
        else if (r_ovf)
            w_result = w_is_rem ? '0 : MIN_VAL;
        else
            w_result = w_is_rem ? w_rem : w_quo;
    end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed RISC-V cases, kill/reset, and continuous random ops.
module tb_iter_divider;

    localparam int W = 32;
    localparam logic [31:0] MIN  = 32'h8000_0000;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;
    localparam int NOPS = 400;

`ifdef DIV_FAST_SPECIAL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, kill;
    logic [1:0]  op;
    logic [31:0] oper_a, oper_b;
    logic        busy, done, divided_by_zero, overflow;
    logic [31:0] div_o;

    int errors = 0;
    int checks = 0;

    iter_divider #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .op              (op),
        .oper_a          (oper_a),
        .oper_b          (oper_b),
        .kill            (kill),
        .busy            (busy),
        .done            (done),
        .div_o           (div_o),
        .divided_by_zero (divided_by_zero),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        dz;
        logic        ovf;
        logic [31:0] res;
    } res_t;

    // Reference: RISC-V M semantics via plain integer arithmetic.
    function automatic res_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        res_t r;
        bit sgn;
        bit rem;
        int sa;
        int sb;
        sgn   = (o == 2'b00) || (o == 2'b10);
        rem   = o[1];
        r.dz  = (b == 32'd0);
        r.ovf = sgn && (a == MIN) && (b == ONES);
        sa    = $signed(a);
        sb    = $signed(b);
        if (r.dz)       r.res = rem ? a : ONES;
        else if (r.ovf) r.res = rem ? 32'd0 : MIN;
        else if (sgn)   r.res = rem ? 32'(sa % sb) : 32'(sa / sb);
        else            r.res = rem ? (a % b) : (a / b);
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Issue one op at the current cycle (cycle 0) and check busy/done timing and the result.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic edz,
                          input logic eovf);
        int lat;
        lat = (FAST && (edz || eovf)) ? 1 : W + 1;
        op = o; oper_a = a; oper_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        op = 2'($urandom); oper_a = $urandom; oper_b = $urandom;
        for (int c = 1; c <= lat; c++) begin
            chk1({tag, "_busy"}, busy, 1'b1);
            if (c < lat) begin
                chk1({tag, "_early_done"}, done, 1'b0);
            end else begin
                chk1({tag, "_done"}, done, 1'b1);
                chk({tag, "_res"}, div_o, er);
                chk1({tag, "_dz"}, divided_by_zero, edz);
                chk1({tag, "_ovf"}, overflow, eovf);
            end
            tick();
        end
        chk1({tag, "_idle"}, busy, 1'b0);
        chk1({tag, "_pulse"}, done, 1'b0);
        chk({tag, "_hold"}, div_o, er);
    endtask

    initial begin
        int   c, acc, ndone, acc_c, done_c, lat, sel;
        bit   pend, exp_busy, exp_done;
        res_t exp_r;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        rst = 1'b1; start = 1'b0; kill = 1'b0; op = 2'b00; oper_a = '0; oper_b = '0;
        tick(); tick();
        rst = 1'b0;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk("rst_div_o", div_o, 32'd0);
        chk1("rst_dz", divided_by_zero, 1'b0);
        chk1("rst_ovf", overflow, 1'b0);
        tick();

        run_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("remu_bigb",  2'b11, 32'd7,         32'h8000_0000, 32'd7,        1'b0, 1'b0);
        run_op("divu_max",   2'b01, ONES,          32'd1,        ONES,          1'b0, 1'b0);
        run_op("divu_dz",    2'b01, 32'd5,         32'd0,        ONES,          1'b1, 1'b0);
        run_op("rem_dz",     2'b10, 32'd5,         32'd0,        32'd5,         1'b1, 1'b0);
        run_op("remu_dz",    2'b11, 32'hDEAD_BEEF, 32'd0,        32'hDEAD_BEEF, 1'b1, 1'b0);
        run_op("div_ovf",    2'b00, MIN,           ONES,         MIN,           1'b0, 1'b1);
        run_op("rem_ovf",    2'b10, MIN,           ONES,         32'd0,         1'b0, 1'b1);
        run_op("divu_minm1", 2'b01, MIN,           ONES,         32'd0,         1'b0, 1'b0);
        run_op("div_pre",    2'b00, 32'd100,       32'd7,        32'd14,        1'b0, 1'b0);

        // Kill at cycle 10 of a DIV, restart at cycle 12.
        op = 2'b00; oper_a = 32'd1234; oper_b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            chk1("kill_no_done", done, 1'b0);
            tick();
        end
        kill = 1'b1;
        chk1("kill_busy_c10", busy, 1'b1);
        tick();
        kill = 1'b0;
        chk1("kill_busy_c11", busy, 1'b0);
        chk1("kill_done_c11", done, 1'b0);
        chk("kill_hold_c11", div_o, 32'd14);
        tick();
        chk1("kill_done_c12", done, 1'b0);
        run_op("div_after_kill", 2'b00, 32'd1000, 32'hFFFF_FFF6, 32'hFFFF_FF9C, 1'b0, 1'b0);

        // kill and start together in IDLE: nothing accepted.
        op = 2'b00; oper_a = 32'd9; oper_b = 32'd3; start = 1'b1; kill = 1'b1;
        tick();
        start = 1'b0; kill = 1'b0;
        chk1("killstart_busy", busy, 1'b0);
        tick();
        chk1("killstart_done", done, 1'b0);
        chk("killstart_hold", div_o, 32'hFFFF_FF9C);

        // Reset at cycle 5 of an op.
        op = 2'b01; oper_a = 32'd50; oper_b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        rst = 1'b1;
        tick();
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_done", done, 1'b0);
        chk("midrst_div_o", div_o, 32'd0);
        chk1("midrst_dz", divided_by_zero, 1'b0);
        chk1("midrst_ovf", overflow, 1'b0);
        rst = 1'b0;
        tick();
        chk1("midrst_after", busy, 1'b0);

        // start held high with random operands; model decides which cycles accept.
        c = 0; acc = 0; ndone = 0; acc_c = -100; done_c = -1; pend = 1'b0; exp_r = '0;
        while ((acc < NOPS || pend) && c < 20000) begin
            exp_busy = pend && (c > acc_c) && (c <= done_c);
            exp_done = pend && (c == done_c);
            if (done) ndone++;
            chk1("rnd_busy", busy, exp_busy);
            chk1("rnd_done", done, exp_done);
            if (exp_done) begin
                chk("rnd_res", div_o, exp_r.res);
                chk1("rnd_dz", divided_by_zero, exp_r.dz);
                chk1("rnd_ovf", overflow, exp_r.ovf);
                pend = 1'b0;
            end
            sel = $urandom_range(0, 7);
            ro  = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = MIN; rb = ONES; end
            else if (sel == 2) begin
                ra = $urandom_range(0, 255);
                rb = $urandom_range(1, 15);
                if ($urandom_range(0, 1) == 1) ra = -ra;
                if ($urandom_range(0, 1) == 1) rb = -rb;
            end
            op = ro; oper_a = ra; oper_b = rb;
            start = (acc < NOPS);
            if (start && !pend && c > done_c) begin
                exp_r  = model(ro, ra, rb);
                lat    = (FAST && (exp_r.dz || exp_r.ovf)) ? 1 : W + 1;
                acc_c  = c;
                done_c = c + lat;
                pend   = 1'b1;
                acc++;
            end
            tick();
            c++;
        end
        start = 1'b0;
        checks++;
        assert (!pend) else begin
            errors++;
            $error("FAIL rnd_timeout: op still pending after %0d cycles", c);
        end
        chk("rnd_done_count", 32'(ndone), 32'(acc));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
